uart_pkt_parser: RTL and testbench

- Upstream framing stage between the uart_rx byte stream and the command datapath (ALU).
- Consumes raw bytes and parses the 4-byte command header: opcode, reserved, length LSB, length MSB. Length is the total frame size including the header.
- Presents the header once on a header channel, then emits the payload as big-endian 32-bit words with a last flag and a valid-byte count.
- Detects malformed lengths and inter-byte timeouts so a lost byte cannot wedge the downstream datapath.

---
 rtl/uart_pkt_parser.sv | 162 ++++++++++++++++
 tb/tb_uart_pkt_parser.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_pkt_parser.sv
// Byte-stream framer between uart_rx and the command datapath: parses a 4-byte header
// (opcode, reserved, length LSB/MSB) and repacks the payload into big-endian 32-bit words.
module uart_pkt_parser #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int CNT_WIDTH      = 17
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [7:0]  s_tdata_i,
    input  logic        s_tvalid_i,
    output logic        s_tready_o,
    output logic        hdr_valid_o,
    input  logic        hdr_ready_i,
    output logic [7:0]  hdr_opcode_o,
    output logic [15:0] hdr_length_o,
    output logic [31:0] word_tdata_o,
    output logic        word_tvalid_o,
    input  logic        word_tready_i,
    output logic        word_tlast_o,
    output logic [2:0]  word_nbytes_o,
    output logic        abort_o,
    output logic        len_err_o
);

    localparam logic [1:0] ST_HDR      = 2'd0;
    localparam logic [1:0] ST_HDR_OUT  = 2'd1;
    localparam logic [1:0] ST_PAYLOAD  = 2'd2;
    localparam logic [1:0] ST_WORD_OUT = 2'd3;

    localparam bit                   TIMEOUT_EN   = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [1:0]           state;
    logic [1:0]           idx;
    logic [7:0]           opcode;
    logic [15:0]          length;
    logic [15:0]          remaining;
    logic [31:0]          word;
    logic [2:0]           nbytes;
    logic                 tlast;
    logic [CNT_WIDTH-1:0] timer;
    logic                 running;
    logic                 abort;
    logic                 len_err;

    logic                 accept;
    logic                 timer_run;
    logic                 expire;
    logic [15:0]          rem_next;
    logic [15:0]          byte_len;
    logic                 word_done;

    // running keeps s_tready_o low while reset is asserted even though the state is HDR
    assign s_tready_o    = running && ((state == ST_HDR) || (state == ST_PAYLOAD));
    assign hdr_valid_o   = (state == ST_HDR_OUT);
    assign word_tvalid_o = (state == ST_WORD_OUT);
    assign hdr_opcode_o  = opcode;
    assign hdr_length_o  = length;
    assign word_tdata_o  = word;
    assign word_tlast_o  = tlast;
    assign word_nbytes_o = nbytes;
    assign abort_o       = abort;
    assign len_err_o     = len_err;

    assign accept    = s_tvalid_i && s_tready_o;
    assign timer_run = ((state == ST_HDR) && (idx != 2'd0)) || (state == ST_PAYLOAD);
    // An accepted byte on the expiry cycle wins over the timeout
    assign expire    = TIMEOUT_EN && timer_run && !accept && (timer == TIMEOUT_LAST);
    assign rem_next  = remaining - 16'd1;
    assign byte_len  = {s_tdata_i, length[7:0]};
    assign word_done = (idx == 2'd3) || (rem_next == 16'd0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            timer <= '0;
        end else if (accept || !timer_run || expire || !TIMEOUT_EN) begin
            timer <= '0;
        end else begin
            timer <= timer + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= ST_HDR;
            idx       <= 2'd0;
            opcode    <= 8'd0;
            length    <= 16'd0;
            remaining <= 16'd0;
            word      <= 32'd0;
            nbytes    <= 3'd0;
            tlast     <= 1'b0;
            running   <= 1'b0;
            abort     <= 1'b0;
            len_err   <= 1'b0;
        end else begin
            running <= 1'b1;
            abort   <= 1'b0;
            len_err <= 1'b0;
            if (expire) begin
                abort <= 1'b1;
                state <= ST_HDR;
                idx   <= 2'd0;
                word  <= 32'd0;
            end else begin
                case (state)
                    ST_HDR: begin
                        if (accept) begin
                            if (idx == 2'd0) opcode <= s_tdata_i;
                            if (idx == 2'd2) length[7:0] <= s_tdata_i;
                            if (idx == 2'd3) length[15:8] <= s_tdata_i;
                            idx <= idx + 2'd1;
                            if (idx == 2'd3) begin
                                if (byte_len < 16'd4) begin
                                    len_err <= 1'b1;
                                end else begin
                                    state     <= ST_HDR_OUT;
                                    remaining <= byte_len - 16'd4;
                                end
                            end
                        end
                    end
                    ST_HDR_OUT: begin
                        if (hdr_ready_i) begin
                            idx   <= 2'd0;
                            word  <= 32'd0;
                            state <= (remaining == 16'd0) ? ST_HDR : ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: begin
                        if (accept) begin
                            case (idx)
                                2'd0:    word[31:24] <= s_tdata_i;
                                2'd1:    word[23:16] <= s_tdata_i;
                                2'd2:    word[15:8]  <= s_tdata_i;
                                default: word[7:0]   <= s_tdata_i;
                            endcase
                            remaining <= rem_next;
                            if (word_done) begin
                                state  <= ST_WORD_OUT;
                                nbytes <= {1'b0, idx} + 3'd1;
                                tlast  <= (rem_next == 16'd0);
                            end else begin
                                idx <= idx + 2'd1;
                            end
                        end
                    end
                    default: begin
                        if (word_tready_i) begin
                            word   <= 32'd0;
                            idx    <= 2'd0;
                            nbytes <= 3'd0;
                            tlast  <= 1'b0;
                            state  <= tlast ? ST_HDR : ST_PAYLOAD;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_pkt_parser.sv
// Randomized self-checking bench for uart_pkt_parser; expected headers and words come
// from a queue-based frame model that chunks each payload into big-endian words.
module tb_uart_pkt_parser;

    localparam int TO = 20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        hdr_valid;
    logic        hdr_ready;
    logic [7:0]  hdr_opcode;
    logic [15:0] hdr_length;
    logic [31:0] word_tdata;
    logic        word_tvalid;
    logic        word_tready;
    logic        word_tlast;
    logic [2:0]  word_nbytes;
    logic        abort;
    logic        len_err;
    logic [64:0] all_out;

    int checks = 0;
    int errors = 0;

    logic [7:0]  frame[$];
    logic [7:0]  obs_op[$];
    logic [15:0] obs_len[$];
    logic [35:0] obs_word[$];
    logic [7:0]  exp_op[$];
    logic [15:0] exp_len[$];
    logic [35:0] exp_word[$];
    int          obs_abort;
    int          obs_lenerr;
    int          exp_lenerr;

    uart_pkt_parser #(.TIMEOUT_CYCLES(TO), .CNT_WIDTH(8)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .s_tdata_i(s_tdata), .s_tvalid_i(s_tvalid), .s_tready_o(s_tready),
        .hdr_valid_o(hdr_valid), .hdr_ready_i(hdr_ready),
        .hdr_opcode_o(hdr_opcode), .hdr_length_o(hdr_length),
        .word_tdata_o(word_tdata), .word_tvalid_o(word_tvalid), .word_tready_i(word_tready),
        .word_tlast_o(word_tlast), .word_nbytes_o(word_nbytes),
        .abort_o(abort), .len_err_o(len_err)
    );

    assign all_out = {s_tready, hdr_valid, hdr_opcode, hdr_length, word_tdata,
                      word_tvalid, word_tlast, word_nbytes, abort, len_err};

    always #5 clk = ~clk;

    // Records every handshake and pulse the DUT produces
    always @(posedge clk) begin
        if (rst_n) begin
            if (hdr_valid && hdr_ready) begin
                obs_op.push_back(hdr_opcode);
                obs_len.push_back(hdr_length);
            end
            if (word_tvalid && word_tready) obs_word.push_back({word_tlast, word_nbytes, word_tdata});
            if (abort) obs_abort++;
            if (len_err) obs_lenerr++;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic clear_obs();
        obs_op.delete(); obs_len.delete(); obs_word.delete();
        exp_op.delete(); exp_len.delete(); exp_word.delete();
        obs_abort = 0; obs_lenerr = 0; exp_lenerr = 0;
    endtask

    task automatic make_frame(input logic [7:0] op, input logic [15:0] len, input int npay);
        frame.delete();
        frame.push_back(op);
        frame.push_back(8'($urandom));
        frame.push_back(len[7:0]);
        frame.push_back(len[15:8]);
        for (int i = 0; i < npay; i++) frame.push_back(8'($urandom));
    endtask

    // Reference: header once if length >= 4, then payload in 4-byte big-endian chunks
    task automatic model_frame();
        int len, pay, n;
        logic [31:0] w;
        len = int'({frame[3], frame[2]});
        if (len < 4) begin
            exp_lenerr++;
            return;
        end
        exp_op.push_back(frame[0]);
        exp_len.push_back(16'(len));
        pay = len - 4;
        for (int i = 0; i < pay; i += 4) begin
            n = (pay - i >= 4) ? 4 : pay - i;
            w = 32'd0;
            for (int j = 0; j < n; j++) w = w | (32'(frame[4 + i + j]) << (24 - 8 * j));
            exp_word.push_back({(i + n == pay), 3'(n), w});
        end
    endtask

    // Called right after a negedge; returns at the negedge following acceptance
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        s_tdata = b;
        s_tvalid = 1'b1;
        while (s_tready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            checks++;
            errors++;
            $display("[TB] FAIL send_byte: s_tready stuck low, got %b required 1", s_tready);
        end
        @(negedge clk);
        s_tvalid = 1'b0;
    endtask

    task automatic send_frame(input int min_gap, input int max_gap);
        for (int i = 0; i < frame.size(); i++) begin
            if (i > 0) repeat ($urandom_range(min_gap, max_gap)) @(negedge clk);
            send_byte(frame[i]);
        end
    endtask

    task automatic drain();
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (all_out !== 65'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h required 0", all_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (s_tready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_tready: got %b required 1", s_tready);
        end
    endtask

    task automatic test_add_frame();
        clear_obs();
        frame = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h05,
                  8'h00, 8'h00, 8'h00, 8'h07};
        send_frame(0, 2);
        drain();
        checks++;
        if (obs_op.size() != 1 || obs_word.size() != 2) begin
            errors++;
            $display("[TB] FAIL add_counts: got hdr=%0d words=%0d required hdr=1 words=2",
                     obs_op.size(), obs_word.size());
        end else begin
            checks++;
            if (obs_op[0] !== 8'hAD || obs_len[0] !== 16'd12) begin
                errors++;
                $display("[TB] FAIL add_header: got op=%h len=%0d required op=ad len=12", obs_op[0], obs_len[0]);
            end
            checks++;
            if (obs_word[0] !== {1'b0, 3'd4, 32'h0000_0005}) begin
                errors++;
                $display("[TB] FAIL add_word0: got %h required %h", obs_word[0], {1'b0, 3'd4, 32'h5});
            end
            checks++;
            if (obs_word[1] !== {1'b1, 3'd4, 32'h0000_0007}) begin
                errors++;
                $display("[TB] FAIL add_word1: got %h required %h", obs_word[1], {1'b1, 3'd4, 32'h7});
            end
        end
    endtask

    task automatic test_odd_echo();
        clear_obs();
        frame = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43};
        send_frame(0, 2);
        drain();
        checks++;
        if (obs_word.size() != 1 || obs_len.size() != 1) begin
            errors++;
            $display("[TB] FAIL echo_counts: got hdr=%0d words=%0d required 1 and 1", obs_len.size(), obs_word.size());
        end else begin
            checks++;
            if (obs_word[0] !== {1'b1, 3'd3, 32'h4142_4300} || obs_len[0] !== 16'd7) begin
                errors++;
                $display("[TB] FAIL echo_word: got %h len=%0d required %h len=7",
                         obs_word[0], obs_len[0], {1'b1, 3'd3, 32'h4142_4300});
            end
        end
    endtask

    task automatic test_short_frames();
        clear_obs();
        make_frame(8'h11, 16'd4, 0);  model_frame(); send_frame(0, 2);
        make_frame(8'h22, 16'd9, 5);  model_frame(); send_frame(0, 2);
        make_frame(8'h33, 16'd2, 0);  model_frame(); send_frame(0, 2);
        make_frame(8'h44, 16'd0, 0);  model_frame(); send_frame(0, 2);
        make_frame(8'h55, 16'd8, 4);  model_frame(); send_frame(0, 2);
        drain();
        checks++;
        if (obs_lenerr != exp_lenerr || obs_op.size() != exp_op.size() || obs_word.size() != exp_word.size()) begin
            errors++;
            $display("[TB] FAIL short_counts: got lenerr=%0d hdr=%0d words=%0d required %0d %0d %0d",
                     obs_lenerr, obs_op.size(), obs_word.size(), exp_lenerr, exp_op.size(), exp_word.size());
        end
        for (int i = 0; i < exp_op.size() && i < obs_op.size(); i++) begin
            checks++;
            if (obs_op[i] !== exp_op[i] || obs_len[i] !== exp_len[i]) begin
                errors++;
                $display("[TB] FAIL short_hdr%0d: got %h/%0d required %h/%0d", i, obs_op[i], obs_len[i], exp_op[i], exp_len[i]);
            end
        end
        for (int i = 0; i < exp_word.size() && i < obs_word.size(); i++) begin
            checks++;
            if (obs_word[i] !== exp_word[i]) begin
                errors++;
                $display("[TB] FAIL short_word%0d: got %h required %h", i, obs_word[i], exp_word[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        logic [31:0] held;
        logic bad;
        clear_obs();
        word_tready = 1'b0;
        make_frame(8'h5A, 16'd16, 12);
        model_frame();
        fork
            send_frame(0, 0);
        join_none
        n = 0;
        while (word_tvalid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("[TB] FAIL bp_wait: word_tvalid got %b required 1", word_tvalid);
        end
        held = word_tdata;
        bad = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (s_tready !== 1'b0 || word_tvalid !== 1'b1 || word_tdata !== held || abort !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("[TB] FAIL bp_hold: got tready=%b tvalid=%b data=%h required 0 1 %h", s_tready, word_tvalid, word_tdata, held);
        end
        word_tready = 1'b1;
        wait fork;
        drain();
        checks++;
        if (obs_word.size() != exp_word.size() || obs_abort != 0) begin
            errors++;
            $display("[TB] FAIL bp_counts: got words=%0d aborts=%0d required %0d 0", obs_word.size(), obs_abort, exp_word.size());
        end
        for (int i = 0; i < exp_word.size() && i < obs_word.size(); i++) begin
            checks++;
            if (obs_word[i] !== exp_word[i]) begin
                errors++;
                $display("[TB] FAIL bp_word%0d: got %h required %h", i, obs_word[i], exp_word[i]);
            end
        end
    endtask

    task automatic test_timeout();
        int n;
        clear_obs();
        make_frame(8'h77, 16'd12, 2);
        send_frame(0, 0);
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (abort === 1'b1) break;
        end
        checks++;
        if (n != TO) begin
            errors++;
            $display("[TB] FAIL timeout_delay: got %0d cycles required %0d", n, TO);
        end
        @(posedge clk);
        #1;
        checks++;
        if (abort !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_pulse: abort got %b required 0", abort);
        end
        @(negedge clk);
        checks++;
        if (obs_word.size() != 0 || obs_abort != 1) begin
            errors++;
            $display("[TB] FAIL timeout_words: got words=%0d aborts=%0d required 0 1", obs_word.size(), obs_abort);
        end
        // Gaps of TO-1 idle cycles sit exactly on the expiry boundary and must not abort
        clear_obs();
        make_frame(8'h31, 16'd10, 6);
        model_frame();
        send_frame(TO - 1, TO - 1);
        drain();
        checks++;
        if (obs_abort != 0 || obs_word.size() != exp_word.size() || obs_op.size() != 1) begin
            errors++;
            $display("[TB] FAIL edge_counts: got aborts=%0d words=%0d hdr=%0d required 0 %0d 1",
                     obs_abort, obs_word.size(), obs_op.size(), exp_word.size());
        end
        for (int i = 0; i < exp_word.size() && i < obs_word.size(); i++) begin
            checks++;
            if (obs_word[i] !== exp_word[i]) begin
                errors++;
                $display("[TB] FAIL edge_word%0d: got %h required %h", i, obs_word[i], exp_word[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        clear_obs();
        send_byte(8'hAD);
        send_byte(8'h00);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (all_out !== 65'd0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: got %h required 0", all_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        frame = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h05,
                  8'h00, 8'h00, 8'h00, 8'h07};
        send_frame(0, 1);
        drain();
        checks++;
        if (obs_word.size() != 2 || obs_abort != 0 || obs_len.size() != 1) begin
            errors++;
            $display("[TB] FAIL midreset_counts: got words=%0d aborts=%0d hdr=%0d required 2 0 1",
                     obs_word.size(), obs_abort, obs_len.size());
        end else begin
            checks++;
            if (obs_len[0] !== 16'd12 || obs_word[1] !== {1'b1, 3'd4, 32'h0000_0007}) begin
                errors++;
                $display("[TB] FAIL midreset_data: got len=%0d word=%h required 12 %h", obs_len[0], obs_word[1], {1'b1, 3'd4, 32'h7});
            end
        end
    endtask

    task automatic test_random();
        bit done;
        clear_obs();
        done = 1'b0;
        fork
            begin
                for (int f = 0; f < 25; f++) begin
                    int np;
                    if ($urandom_range(0, 9) == 0) begin
                        make_frame(8'($urandom), 16'($urandom_range(0, 3)), 0);
                    end else begin
                        np = $urandom_range(0, 13);
                        make_frame(8'($urandom), 16'(np + 4), np);
                    end
                    model_frame();
                    send_frame(0, 3);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    hdr_ready = 1'($urandom_range(0, 1));
                    word_tready = 1'($urandom_range(0, 1));
                end
            end
        join
        hdr_ready = 1'b1;
        word_tready = 1'b1;
        drain();
        checks++;
        if (obs_lenerr != exp_lenerr || obs_op.size() != exp_op.size() ||
            obs_word.size() != exp_word.size() || obs_abort != 0) begin
            errors++;
            $display("[TB] FAIL rand_counts: got lenerr=%0d hdr=%0d words=%0d aborts=%0d required %0d %0d %0d 0",
                     obs_lenerr, obs_op.size(), obs_word.size(), obs_abort, exp_lenerr, exp_op.size(), exp_word.size());
        end
        for (int i = 0; i < exp_op.size() && i < obs_op.size(); i++) begin
            checks++;
            if (obs_op[i] !== exp_op[i] || obs_len[i] !== exp_len[i]) begin
                errors++;
                $display("[TB] FAIL rand_hdr%0d: got %h/%0d required %h/%0d", i, obs_op[i], obs_len[i], exp_op[i], exp_len[i]);
            end
        end
        for (int i = 0; i < exp_word.size() && i < obs_word.size(); i++) begin
            checks++;
            if (obs_word[i] !== exp_word[i]) begin
                errors++;
                $display("[TB] FAIL rand_word%0d: got %h required %h", i, obs_word[i], exp_word[i]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        s_tdata = 8'd0;
        s_tvalid = 1'b0;
        hdr_ready = 1'b1;
        word_tready = 1'b1;
        clear_obs();
        test_reset();
        test_add_frame();
        test_odd_echo();
        test_short_frames();
        test_backpressure();
        test_timeout();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
